// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: the upstream controllers' Wishbone signals,
// the shared downstream device port and the grant vector.
interface wb_rr_arbiter_if #(
    parameter int NUM_CTRL   = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_CTRL-1:0]            ctrl_cyc_i;
    logic [NUM_CTRL-1:0]            ctrl_stb_i;
    logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_dat_i;
    logic [NUM_CTRL-1:0]            ctrl_stall_o;
    logic [NUM_CTRL-1:0]            ctrl_ack_o;
    logic                           dev_cyc_o;
    logic                           dev_stb_o;
    logic [DATA_WIDTH-1:0]          dev_dat_o;
    logic                           dev_stall_i;
    logic                           dev_ack_i;
    logic [NUM_CTRL-1:0]            grant_o;

    modport slave (
        input  ctrl_cyc_i, ctrl_stb_i, ctrl_dat_i, dev_stall_i, dev_ack_i,
        output ctrl_stall_o, ctrl_ack_o, dev_cyc_o, dev_stb_o, dev_dat_o, grant_o
    );

    modport master (
        output ctrl_cyc_i, ctrl_stb_i, ctrl_dat_i, dev_stall_i, dev_ack_i,
        input  ctrl_stall_o, ctrl_ack_o, dev_cyc_o, dev_stb_o, dev_dat_o, grant_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone device between NUM_CTRL
// controllers; the grant is held for a whole bus cycle and in-flight acks are counted.
module wb_rr_arbiter #(
    parameter int NUM_CTRL   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_OUTST  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_rr_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_CTRL);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    localparam logic [IDX_W-1:0]    PTR_RST  = IDX_W'(NUM_CTRL - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_CTRL-1:0] ONE_HOT0 = NUM_CTRL'(1);

    logic [0:0]          state_r;
    logic [NUM_CTRL-1:0] grant_r;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    outst_r;

    logic                  pick_valid_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic [IDX_W-1:0]      cand_s;
    logic                  granted_s;
    logic                  g_cyc_s;
    logic                  g_stb_s;
    logic                  limit_s;
    logic                  outst_nz_s;
    logic                  accept_s;
    logic                  ack_eff_s;
    logic                  dev_cyc_s;
    logic                  dev_stb_s;
    logic [DATA_WIDTH-1:0] dev_dat_s;
    logic [NUM_CTRL-1:0]   stall_s;
    logic [NUM_CTRL-1:0]   ack_s;

    assign granted_s  = (state_r == ST_GRANTED);
    assign g_cyc_s    = bus.ctrl_cyc_i[idx_r];
    assign g_stb_s    = bus.ctrl_stb_i[idx_r];
    assign limit_s    = (outst_r == CNT_MAX);
    assign outst_nz_s = (outst_r != '0);
    assign accept_s   = dev_stb_s & ~bus.dev_stall_i;
    // An ack with nothing outstanding is spurious and must not disturb the count.
    assign ack_eff_s  = granted_s & bus.dev_ack_i & outst_nz_s;

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 1; i <= NUM_CTRL; i++) begin
            cand_s = IDX_W'((int'(ptr_r) + i) % NUM_CTRL);
            if (!pick_valid_s && bus.ctrl_cyc_i[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Route the granted controller to the device; everyone else is stalled.
    always_comb begin
        dev_cyc_s = 1'b0;
        dev_stb_s = 1'b0;
        dev_dat_s = '0;
        stall_s   = bus.ctrl_cyc_i & bus.ctrl_stb_i;
        ack_s     = '0;
        if (granted_s) begin
            dev_cyc_s      = g_cyc_s;
            dev_stb_s      = g_stb_s & g_cyc_s & ~limit_s;
            dev_dat_s      = bus.ctrl_dat_i[idx_r*DATA_WIDTH +: DATA_WIDTH];
            stall_s[idx_r] = g_stb_s & (bus.dev_stall_i | limit_s);
            ack_s[idx_r]   = bus.dev_ack_i & outst_nz_s;
        end else begin
            dev_cyc_s = 1'b0;
            dev_stb_s = 1'b0;
        end
    end

    assign bus.dev_cyc_o    = dev_cyc_s;
    assign bus.dev_stb_o    = dev_stb_s;
    assign bus.dev_dat_o    = dev_dat_s;
    assign bus.ctrl_stall_o = stall_s;
    assign bus.ctrl_ack_o   = ack_s;
    assign bus.grant_o      = grant_r;

    // Grant FSM and outstanding-transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            idx_r   <= '0;
            ptr_r   <= PTR_RST;
            outst_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r <= ST_GRANTED;
                        grant_r <= ONE_HOT0 << pick_idx_s;
                        idx_r   <= pick_idx_s;
                        ptr_r   <= pick_idx_s;
                        outst_r <= '0;
                    end else begin
                        grant_r <= '0;
                        outst_r <= '0;
                    end
                end
                ST_GRANTED: begin
                    // Normal end and abort look the same: pending acks are forgotten.
                    if (!g_cyc_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                        outst_r <= '0;
                    end else if (accept_s && !ack_eff_s) begin
                        outst_r <= outst_r + CNT_ONE;
                    end else if (ack_eff_s && !accept_s) begin
                        outst_r <= outst_r - CNT_ONE;
                    end else begin
                        outst_r <= outst_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    outst_r <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a vector table for single/dual-controller
// traffic plus hand sequences for fairness, throttling, abort and reset.
module tb_wb_rr_arbiter;
    localparam int NC = 4;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    wb_rr_arbiter_if #(.NUM_CTRL(NC), .DATA_WIDTH(DW)) bus();

    wb_rr_arbiter #(.NUM_CTRL(NC), .DATA_WIDTH(DW), .MAX_OUTST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic [31:0] dat;
        logic        dstall;
        logic        dack;
        logic [3:0]  e_grant;
        logic        e_cyc;
        logic        e_stb;
        logic [7:0]  e_dat;
        logic [3:0]  e_stall;
        logic [3:0]  e_ack;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic [31:0] dat,
                         input logic dstall, input logic dack);
        bus.ctrl_cyc_i  = cyc;
        bus.ctrl_stb_i  = stb;
        bus.ctrl_dat_i  = dat;
        bus.dev_stall_i = dstall;
        bus.dev_ack_i   = dack;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, bus.grant_o, bus.dev_cyc_o, bus.dev_stb_o, bus.dev_dat_o,
                bus.ctrl_stall_o, bus.ctrl_ack_o};
    endfunction

    initial begin
        logic [31:0] exp_v;
        logic [3:0]  exp_g;
        int          order[5];
        total = 0;
        bad   = 0;
        // ctrl0 single transfer, then ctrl1/ctrl2 contention
        vecs[0]  = '{4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0};
        vecs[1]  = '{4'h1, 4'h1, 32'h000000A5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h1, 4'h0};
        vecs[2]  = '{4'h1, 4'h1, 32'h000000A5, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 4'h0, 4'h0};
        vecs[3]  = '{4'h1, 4'h0, 32'h000000A5, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 8'hA5, 4'h0, 4'h1};
        vecs[4]  = '{4'h0, 4'h0, 32'h000000A5, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 8'hA5, 4'h0, 4'h0};
        vecs[5]  = '{4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0};
        vecs[6]  = '{4'h6, 4'h6, 32'h00221100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h6, 4'h0};
        vecs[7]  = '{4'h6, 4'h6, 32'h00221100, 1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 8'h11, 4'h4, 4'h0};
        vecs[8]  = '{4'h6, 4'h4, 32'h00221100, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 8'h11, 4'h4, 4'h2};
        vecs[9]  = '{4'h4, 4'h4, 32'h00221100, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 8'h11, 4'h4, 4'h0};
        vecs[10] = '{4'h4, 4'h4, 32'h00221100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h4, 4'h0};
        vecs[11] = '{4'h4, 4'h4, 32'h00221100, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 8'h22, 4'h0, 4'h0};
        vecs[12] = '{4'h4, 4'h0, 32'h00221100, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 8'h22, 4'h0, 4'h4};
        vecs[13] = '{4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0};

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        #3;
        chk("reset_outputs", outs(), 32'h0);
        do_reset();

        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].cyc, vecs[v].stb, vecs[v].dat, vecs[v].dstall, vecs[v].dack);
            #2;
            exp_v = {10'd0, vecs[v].e_grant, vecs[v].e_cyc, vecs[v].e_stb, vecs[v].e_dat,
                     vecs[v].e_stall, vecs[v].e_ack};
            chk($sformatf("vec%0d", v), outs(), exp_v);
            step();
        end

        // all four hold cyc: one transfer each, grant rotates 0,1,2,3,0
        do_reset();
        order = '{0, 1, 2, 3, 0};
        drive(4'hF, 4'h0, 32'h44332211, 1'b0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            exp_g = 4'b0001 << order[r];
            #2;
            chk("rr_idle", {28'd0, bus.grant_o}, 32'h0);
            step();
            #2;
            chk($sformatf("rr_grant%0d", r), {28'd0, bus.grant_o}, {28'd0, exp_g});
            bus.ctrl_stb_i = exp_g;
            #1;
            chk("rr_stb", {27'd0, bus.dev_stb_o, bus.ctrl_ack_o}, 32'h10);
            step();
            bus.ctrl_stb_i = 4'h0;
            bus.dev_ack_i  = 1'b1;
            #2;
            chk($sformatf("rr_ack%0d", r), {28'd0, bus.ctrl_ack_o}, {28'd0, exp_g});
            step();
            bus.dev_ack_i  = 1'b0;
            bus.ctrl_cyc_i = 4'hF & ~exp_g;
            step();
            bus.ctrl_cyc_i = 4'hF;
        end

        // outstanding limit: device never acks, ctrl0 streams
        do_reset();
        drive(4'h1, 4'h1, 32'h5A, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("lim_accept%0d", i), {30'd0, bus.dev_stb_o, bus.ctrl_stall_o[0]}, 32'h2);
            step();
        end
        #2;
        chk("lim_full", {30'd0, bus.dev_stb_o, bus.ctrl_stall_o[0]}, 32'h1);
        bus.dev_ack_i = 1'b1;
        #1;
        chk("lim_full_ack", {30'd0, bus.dev_stb_o, bus.ctrl_stall_o[0]}, 32'h1);
        step();
        bus.dev_ack_i = 1'b0;
        #2;
        chk("lim_reaccept", {30'd0, bus.dev_stb_o, bus.ctrl_stall_o[0]}, 32'h2);
        step();
        #2;
        chk("lim_full2", {30'd0, bus.dev_stb_o, bus.ctrl_stall_o[0]}, 32'h1);

        // abort with two acks pending
        do_reset();
        drive(4'h1, 4'h1, 32'h77, 1'b0, 1'b0);
        step();
        step();
        step();
        drive(4'h0, 4'h0, 32'h77, 1'b0, 1'b0);
        #2;
        chk("abort_hold", {28'd0, bus.grant_o}, 32'h1);
        step();
        #2;
        chk("abort_release", {27'd0, bus.grant_o, bus.dev_cyc_o}, 32'h0);
        bus.dev_ack_i = 1'b1;
        #1;
        chk("abort_late_ack", {28'd0, bus.ctrl_ack_o}, 32'h0);
        step();
        bus.dev_ack_i  = 1'b0;
        bus.ctrl_cyc_i = 4'h1;
        step();
        #2;
        chk("abort_regrant", {28'd0, bus.grant_o}, 32'h1);
        bus.dev_ack_i = 1'b1;
        #1;
        chk("abort_cnt_cleared", {28'd0, bus.ctrl_ack_o}, 32'h0);
        step();
        drive(4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();

        // asynchronous reset mid-burst
        do_reset();
        drive(4'h2, 4'h2, 32'h00003C00, 1'b0, 1'b0);
        step();
        #2;
        chk("rst_pre_grant", {28'd0, bus.grant_o}, 32'h2);
        step();
        #2;
        chk("rst_pre_cyc", {31'd0, bus.dev_cyc_o}, 32'h1);
        rst_n         = 1'b0;
        bus.dev_ack_i = 1'b1;
        #1;
        chk("rst_async", {23'd0, bus.grant_o, bus.dev_cyc_o, bus.ctrl_ack_o}, 32'h0);
        drive(4'h3, 4'h0, 32'h00003C00, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        #2;
        chk("rst_ctrl0_first", {28'd0, bus.grant_o}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
